// File: rtl/sa_pkg.sv
// Shared types and constants for the 2x2 systolic array feeder and its tag pipeline.
package sa_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD0,
        LOAD1,
        STREAM,
        DRAIN
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } tag_t;

    localparam logic [2:0] CSEL_IDLE = 3'b000;
    localparam logic [2:0] CSEL_ACC  = 3'b100;

    // Accumulate-into-slot select for a live tag, idle select otherwise.
    function automatic logic [2:0] csel_of(input tag_t t);
        return t.valid ? (CSEL_ACC | {1'b0, t.idx}) : CSEL_IDLE;
    endfunction

endpackage

// File: rtl/sa_tag_pipe.sv
// {valid, idx} shift register that follows each accepted vector through the array latency.
module sa_tag_pipe
    import sa_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  tag_t in_tag,
    output tag_t out_tag
);

    tag_t tag_p [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_p[i] <= '0;
            end
        end else begin
            tag_p[0] <= in_tag;
            for (int i = 1; i < DEPTH; i++) begin
                tag_p[i] <= tag_p[i-1];
            end
        end
    end

    assign out_tag = tag_p[DEPTH-1];

endmodule

// File: rtl/sa2x2_feeder.sv
// Operand sequencer and result collector for the 2x2 systolic array: weight load,
// skewed activation streaming, accumulator select and result capture, one job per start.
module sa2x2_feeder
    import sa_pkg::*;
#(
    parameter int N_VEC = 16,
    parameter int LAT   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] w11,
    input  logic [DATA_W-1:0] w12,
    input  logic [DATA_W-1:0] w21,
    input  logic [DATA_W-1:0] w22,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] a1,
    output logic [DATA_W-1:0] A_in_1,
    output logic [DATA_W-1:0] A_in_2,
    output logic [DATA_W-1:0] B_in_1,
    output logic [DATA_W-1:0] B_in_2,
    output logic [1:0]        P2_en,
    output logic [2:0]        c_sel,
    input  logic [DATA_W-1:0] SAout,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic              done
);

    localparam logic [7:0] LAST_IDX   = 8'(N_VEC - 1);
    localparam logic [7:0] NVEC_SAT   = 8'(N_VEC);
    localparam logic [7:0] DRAIN_LAST = 8'(LAT + 1);

    state_t            state;
    logic [7:0]        vec_cnt;
    logic [7:0]        drain_cnt;
    logic [DATA_W-1:0] w11_q;
    logic [DATA_W-1:0] w12_q;
    logic [DATA_W-1:0] a1_p0;
    logic              xfer;
    tag_t              tag_p0;
    tag_t              tag_pl;

    assign xfer   = a_valid & a_ready;
    assign tag_p0 = {xfer, (xfer ? vec_cnt[1:0] : 2'b00)};

    // Stage 0 .. LAT-1 of the tag pipeline; the final stage is the c_sel/res_valid register.
    sa_tag_pipe #(
        .DEPTH(LAT)
    ) u_tag_pipe (
        .clk    (clk),
        .rst    (rst),
        .in_tag (tag_p0),
        .out_tag(tag_pl)
    );

    assign res_data = res_valid ? SAout : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            vec_cnt   <= '0;
            drain_cnt <= '0;
            w11_q     <= '0;
            w12_q     <= '0;
            a1_p0     <= '0;
            a_ready   <= 1'b0;
            A_in_1    <= '0;
            A_in_2    <= '0;
            B_in_1    <= '0;
            B_in_2    <= '0;
            P2_en     <= 2'b00;
            c_sel     <= CSEL_IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done      <= 1'b0;
            B_in_1    <= '0;
            B_in_2    <= '0;
            P2_en     <= 2'b00;
            // Bubbles enter the array as zero pairs; the skew register always shifts.
            A_in_1    <= xfer ? a0 : '0;
            a1_p0     <= xfer ? a1 : '0;
            A_in_2    <= a1_p0;
            c_sel     <= csel_of(tag_pl);
            res_valid <= tag_pl.valid;
            if (xfer && vec_cnt != NVEC_SAT) begin
                vec_cnt <= vec_cnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    // The done cycle is itself IDLE, so a start there must be refused.
                    if (start && !done) begin
                        w11_q   <= w11;
                        w12_q   <= w12;
                        vec_cnt <= '0;
                        B_in_1  <= w21;
                        B_in_2  <= w22;
                        P2_en   <= 2'b11;
                        busy    <= 1'b1;
                        state   <= LOAD0;
                    end
                end
                LOAD0: begin
                    B_in_1 <= w11_q;
                    B_in_2 <= w12_q;
                    P2_en  <= 2'b01;
                    state  <= LOAD1;
                end
                LOAD1: begin
                    a_ready <= 1'b1;
                    state   <= STREAM;
                end
                STREAM: begin
                    if (xfer && vec_cnt == LAST_IDX) begin
                        a_ready   <= 1'b0;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
